// File: rtl/flash_prog_ctrl.sv
// SPI NOR command sequencer: expands host commands into WREN / opcode / address / data / status-poll bytes.
// First spi_start 2 cycles after accept; CS stays asserted while program data is not offered (wr_valid low).
module flash_prog_ctrl #(
    parameter int POLL_GAP  = 16,
    parameter int MAX_POLLS = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  status,
    output logic        spi_cs,
    output logic        spi_start,
    output logic [7:0]  spi_tx,
    input  logic [7:0]  spi_rx,
    input  logic        spi_done
);
    localparam int          GAP_W     = $clog2(POLL_GAP + 1);
    localparam logic [15:0] POLL_LAST = 16'(MAX_POLLS - 1);

    localparam logic [1:0] OP_PP   = 2'b00;
    localparam logic [1:0] OP_SE   = 2'b01;
    localparam logic [1:0] OP_RDSR = 2'b10;
    localparam logic [1:0] OP_CE   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_XFER, S_XWAIT, S_CS_GAP, S_DATA_WAIT, S_POLL_GAP, S_DONE
    } state_t;

    // Which flash transaction (one CS assertion) is currently being issued.
    typedef enum logic [1:0] {K_WREN, K_MAIN, K_POLL, K_RDSR} kind_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [23:0] addr;
    } cmd_t;

    state_t             state;
    kind_t              kind;
    cmd_t               cmd;
    logic [1:0]         idx;
    logic [7:0]         len_cnt;
    logic               in_data;
    logic               finish;
    logic [15:0]        poll_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic [1:0]         last_idx;
    logic               enter_data;
    logic               txn_end;

    function automatic logic [7:0] byte_at(input kind_t k, input logic [1:0] i, input cmd_t c);
        logic [7:0] b;
        b = 8'h00;
        case (k)
            K_WREN: b = 8'h06;
            K_MAIN: begin
                case (i)
                    2'd0: begin
                        case (c.op)
                            OP_PP:   b = 8'h02;
                            OP_SE:   b = 8'h20;
                            OP_RDSR: b = 8'h05;
                            default: b = 8'hC7;
                        endcase
                    end
                    2'd1:    b = c.addr[23:16];
                    2'd2:    b = c.addr[15:8];
                    default: b = c.addr[7:0];
                endcase
            end
            default: b = (i == 2'd0) ? 8'h05 : 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        last_idx = 2'd1;
        case (kind)
            K_WREN:  last_idx = 2'd0;
            K_MAIN:  last_idx = (cmd.op == OP_CE) ? 2'd0 : 2'd3;
            default: last_idx = 2'd1;
        endcase
    end

    // Page program leaves the opcode/address phase for the data phase instead of closing CS.
    assign enter_data = !in_data && (kind == K_MAIN) && (cmd.op == OP_PP) && (idx == 2'd3);
    assign txn_end    = in_data ? (len_cnt == 8'd0) : ((idx == last_idx) && !enter_data);

    assign cmd_ready = (state == S_IDLE) && !reset;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            kind      <= K_WREN;
            cmd       <= '0;
            idx       <= '0;
            len_cnt   <= '0;
            in_data   <= 1'b0;
            finish    <= 1'b0;
            poll_cnt  <= '0;
            gap_cnt   <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            status    <= '0;
            spi_cs    <= 1'b0;
            spi_start <= 1'b0;
            spi_tx    <= '0;
            wr_ready  <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd      <= '{op: cmd_op, addr: cmd_addr};
                        len_cnt  <= cmd_len;
                        error    <= 1'b0;
                        poll_cnt <= '0;
                        finish   <= 1'b0;
                        kind     <= (cmd_op == OP_RDSR) ? K_RDSR : K_WREN;
                        spi_cs   <= 1'b1;
                        state    <= S_CS_SETUP;
                    end
                end
                S_CS_SETUP: begin
                    spi_start <= 1'b1;
                    spi_tx    <= byte_at(kind, 2'd0, cmd);
                    idx       <= 2'd0;
                    in_data   <= 1'b0;
                    state     <= S_XFER;
                end
                S_XFER: state <= S_XWAIT;
                S_XWAIT: begin
                    if (spi_done) begin
                        if (txn_end) begin
                            spi_cs  <= 1'b0;
                            gap_cnt <= GAP_W'(1);
                            state   <= S_CS_GAP;
                            case (kind)
                                K_WREN: kind <= K_MAIN;
                                K_MAIN: kind <= K_POLL;
                                K_RDSR: begin
                                    status <= spi_rx;
                                    finish <= 1'b1;
                                end
                                default: begin
                                    status   <= spi_rx;
                                    poll_cnt <= poll_cnt + 16'd1;
                                    if (!spi_rx[0]) begin
                                        finish <= 1'b1;
                                    end else if (poll_cnt == POLL_LAST) begin
                                        error  <= 1'b1;
                                        finish <= 1'b1;
                                    end else begin
                                        gap_cnt <= GAP_W'(POLL_GAP - 1);
                                        state   <= S_POLL_GAP;
                                    end
                                end
                            endcase
                        end else if (enter_data || in_data) begin
                            if (in_data) len_cnt <= len_cnt - 8'd1;
                            wr_ready <= 1'b1;
                            state    <= S_DATA_WAIT;
                        end else begin
                            idx       <= idx + 2'd1;
                            spi_tx    <= byte_at(kind, idx + 2'd1, cmd);
                            spi_start <= 1'b1;
                            state     <= S_XFER;
                        end
                    end
                end
                S_DATA_WAIT: begin
                    if (wr_valid) begin
                        wr_ready  <= 1'b0;
                        spi_tx    <= wr_data;
                        spi_start <= 1'b1;
                        in_data   <= 1'b1;
                        state     <= S_XFER;
                    end
                end
                S_CS_GAP: begin
                    if (gap_cnt == '0) begin
                        if (finish) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            spi_cs <= 1'b1;
                            state  <= S_CS_SETUP;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                S_POLL_GAP: begin
                    if (gap_cnt == '0) begin
                        spi_cs <= 1'b1;
                        state  <= S_CS_SETUP;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_prog_ctrl.sv
// Directed bench for flash_prog_ctrl with a byte-level SPI flash responder (3-cycle byte time).
module tb_flash_prog_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  status;
    logic        spi_cs;
    logic        spi_start;
    logic [7:0]  spi_tx;
    logic [7:0]  spi_rx;
    logic        spi_done;

    always #5 clk = ~clk;

    flash_prog_ctrl #(.POLL_GAP(16), .MAX_POLLS(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .busy(busy), .done(done), .error(error), .status(status),
        .spi_cs(spi_cs), .spi_start(spi_start), .spi_tx(spi_tx),
        .spi_rx(spi_rx), .spi_done(spi_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Responder configuration, written only by the stimulus block.
    logic       always_wip = 1'b0;
    int         wip_target = 0;
    logic [7:0] final_status = 8'h00;

    // Flash responder: status reads return WIP until poll_served reaches wip_target.
    int         resp_cnt = 0;
    int         txn_idx = 0;
    int         poll_served = 0;
    logic [7:0] first_byte = 8'h00;
    logic [7:0] rx_pend = 8'h00;

    initial begin
        spi_done = 1'b0;
        spi_rx   = 8'h00;
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        spi_done = 1'b0;
        if (reset) begin
            resp_cnt = 0;
            txn_idx  = 0;
        end else begin
            if (!spi_cs) txn_idx = 0;
            if (resp_cnt != 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    spi_done = 1'b1;
                    spi_rx   = rx_pend;
                end
            end
            if (spi_start) begin
                resp_cnt = 3;
                rx_pend  = 8'hFF;
                if (txn_idx == 0) first_byte = spi_tx;
                if (txn_idx == 1 && first_byte == 8'h05) begin
                    rx_pend = (always_wip || poll_served < wip_target) ? 8'h01 : final_status;
                    poll_served++;
                end
                txn_idx++;
            end
        end
    end

    // Monitors sample mid-cycle.
    logic [7:0] tx_log[$];
    int         gaps[$];
    int         start_cnt = 0;
    int         done_cnt = 0;
    int         both_viol = 0;
    int         low_run = 0;
    int         sdone_cyc = 0;
    int         done_cyc = 0;

    always @(negedge clk) begin
        if (spi_start) begin
            tx_log.push_back(spi_tx);
            start_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (done && cmd_ready) both_viol++;
        if (spi_done) sdone_cyc = cyc;
        if (!busy) begin
            low_run = 0;
        end else if (!spi_cs) begin
            low_run++;
        end else begin
            if (low_run > 0) gaps.push_back(low_run);
            low_run = 0;
        end
    end

    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int base);
        check({tag, "_len"}, 32'(tx_log.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < tx_log.size())
                check($sformatf("%s_b%0d", tag, i), 32'(tx_log[base + i]), 32'(exp_q[i]));
    endtask

    task automatic issue(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] len);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_issue", 32'(cmd_ready), 1);
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int n;
        n = 0;
        while (!wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wr_ready_wait", 32'(wr_ready), 1);
        wr_data  = d;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 1);
        @(negedge clk);
        check({tag, "_ready_after_done"}, 32'(cmd_ready), 1);
    endtask

    int base, dbase, gbase, sbase, mn, n16, cs_drop, n;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_status", 32'(status), 0);
        check("rst_spi_cs", 32'(spi_cs), 0);
        check("rst_spi_start", 32'(spi_start), 0);
        check("rst_spi_tx", 32'(spi_tx), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 32'(cmd_ready), 1);

        // Page program, two WIP polls then clear.
        base = tx_log.size(); dbase = done_cnt; gbase = gaps.size();
        wip_target = poll_served + 2; final_status = 8'h00;
        issue(2'b00, 24'h012345, 8'd3);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        wait_done("pp");
        repeat (5) @(negedge clk);
        exp_q = '{8'h06, 8'h02, 8'h01, 8'h23, 8'h45, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                  8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00};
        check_seq("pp", base);
        check("pp_done_once", 32'(done_cnt - dbase), 1);
        check("pp_status", 32'(status), 32'h00);
        check("pp_error", 32'(error), 0);
        mn = 1000; n16 = 0;
        for (int i = gbase; i < gaps.size(); i++) begin
            if (gaps[i] < mn) mn = gaps[i];
            if (gaps[i] == 16) n16++;
        end
        check("pp_cs_gap_ge2", 32'(mn >= 2), 1);
        check("pp_poll_gaps_16", 32'(n16), 2);

        // Sector erase, WIP clear on first poll.
        base = tx_log.size(); dbase = done_cnt;
        wip_target = poll_served; final_status = 8'h00;
        issue(2'b01, 24'hABCDEF, 8'd0);
        wait_done("se");
        repeat (5) @(negedge clk);
        exp_q = '{8'h06, 8'h20, 8'hAB, 8'hCD, 8'hEF, 8'h05, 8'h00};
        check_seq("se", base);
        check("se_done_once", 32'(done_cnt - dbase), 1);

        // Read status, first-start latency and done latency.
        base = tx_log.size();
        wip_target = poll_served; final_status = 8'h5C;
        issue(2'b10, 24'h000000, 8'd0);
        check("rd_setup_cs", 32'(spi_cs), 1);
        check("rd_setup_busy", 32'(busy), 1);
        check("rd_setup_nostart", 32'(spi_start), 0);
        @(negedge clk);
        check("rd_first_start", 32'(spi_start), 1);
        wait_done("rd");
        exp_q = '{8'h05, 8'h00};
        check_seq("rd", base);
        check("rd_status", 32'(status), 32'h5C);
        check("rd_done_latency", 32'(done_cyc - sdone_cyc), 3);

        // Data stall of 20 cycles after the first data byte.
        base = tx_log.size();
        wip_target = poll_served; final_status = 8'h00;
        issue(2'b00, 24'h000100, 8'd2);
        send_byte(8'h11);
        n = 0;
        while (!wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_ready", 32'(wr_ready), 1);
        sbase = start_cnt; cs_drop = 0;
        repeat (20) begin
            @(negedge clk);
            if (!spi_cs) cs_drop++;
        end
        check("stall_cs_held", 32'(cs_drop), 0);
        check("stall_no_start", 32'(start_cnt - sbase), 0);
        send_byte(8'h22); send_byte(8'h33);
        wait_done("stall");
        exp_q = '{8'h06, 8'h02, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h05, 8'h00};
        check_seq("stall", base);

        // Chip erase with WIP stuck: times out after MAX_POLLS polls.
        base = tx_log.size(); dbase = done_cnt;
        always_wip = 1'b1;
        issue(2'b11, 24'h000000, 8'd0);
        wait_done("to");
        repeat (5) @(negedge clk);
        exp_q = '{8'h06, 8'hC7, 8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00};
        check_seq("to", base);
        check("to_error", 32'(error), 1);
        check("to_status", 32'(status), 32'h01);
        check("to_done_once", 32'(done_cnt - dbase), 1);
        always_wip = 1'b0; wip_target = poll_served; final_status = 8'h00;
        issue(2'b10, 24'h000000, 8'd0);
        check("to_error_cleared", 32'(error), 0);
        wait_done("to_next");

        // Reset in the middle of the address bytes.
        base = tx_log.size();
        wip_target = poll_served;
        issue(2'b01, 24'h123456, 8'd0);
        n = 0;
        while (tx_log.size() - base < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached_addr", 32'(tx_log.size() - base), 3);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_cs", 32'(spi_cs), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_ready_low", 32'(cmd_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 32'(cmd_ready), 1);
        exp_q = '{8'h06, 8'h20, 8'h12};
        check_seq("rst_mid", base);
        base = tx_log.size();
        final_status = 8'hA5;
        issue(2'b10, 24'h000000, 8'd0);
        wait_done("rst_rd");
        exp_q = '{8'h05, 8'h00};
        check_seq("rst_rd", base);
        check("rst_rd_status", 32'(status), 32'hA5);

        check("done_ready_exclusive", 32'(both_viol), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/flash_prog_ctrl.md
# flash_prog_ctrl

Command sequencer for SPI NOR flash programming. It accepts page-program, sector-erase, chip-erase and read-status commands from a host-side register block. It expands each command into the full JEDEC byte sequence: WREN, opcode, 24-bit address, streamed data, then status polling until WIP clears. It drives a byte-level SPI shifter through a start/done handshake, so the CPU-facing iomem logic never has to sequence flash commands.

## Interface
- POLL_GAP, 16: idle cycles between consecutive status polls (CS deasserted during the gap).
- MAX_POLLS, 65535: polls allowed before a timeout error; 16-bit counter.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid && cmd_ready.
- cmd_op  in  2  command code:
  - 00: page program (0x02).
  - 01: 4 KB sector erase (0x20).
  - 10: read status (0x05).
  - 11: chip erase (0xC7).
- cmd_addr  in  24  flash byte address; ignored for ops 10 and 11.
- cmd_len  in  8  page program byte count minus 1 (0..255 means 1..256 bytes).
- wr_data  in  8  program data byte.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  data byte accepted on wr_valid && wr_ready.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a command completes, including on timeout.
- error  out  1  sticky timeout flag; cleared when the next command is accepted.
- status  out  8  last status byte read from the flash.
- spi_cs  out  1  chip-select request, 1 = selected.
- spi_start  out  1  one-cycle pulse that launches one byte transfer.
- spi_tx  out  8  byte to shift out; held stable from spi_start until spi_done.
- spi_rx  in  8  received byte; valid in the cycle spi_done is high.
- spi_done  in  1  one-cycle pulse marking the end of a byte transfer.

## Operation
- Latched on command accept: cmd_op, cmd_addr, cmd_len (down-counter), error cleared.
- States: IDLE, CS_SETUP, XFER, XWAIT, CS_GAP, DATA_WAIT, POLL_GAP, DONE.
- CS_SETUP asserts spi_cs for one cycle before the first spi_start of every transaction.
- XFER pulses spi_start with spi_tx loaded; XWAIT waits for spi_done.
- After the last byte of a transaction, spi_cs drops in the cycle after spi_done and stays low for at least 2 cycles in CS_GAP.
- Byte sequences per op:
  - 00: [06] gap [02 A23..16 A15..8 A7..0 D0..Dn] gap, then poll.
  - 01: [06] gap [20 A2 A1 A0] gap, then poll.
  - 11: [06] gap [C7] gap, then poll.
  - 10: [05 00]; rx of the second byte goes to status; then DONE with no poll.
- Data phase (DATA_WAIT):
  - wr_ready=1 only while in DATA_WAIT with no transfer in flight.
  - On accept, the byte is registered and spi_start pulses the next cycle.
  - If wr_valid is low, spi_cs stays asserted and the controller waits indefinitely.
  - After the byte with count 0 completes, the transaction closes.
- Poll loop: [05 00] transaction; rx goes to status.
  - status[0]=1: wait POLL_GAP cycles with spi_cs low, then re-poll.
  - status[0]=0: go to DONE.
  - Poll count reaches MAX_POLLS with WIP still set: error=1, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address is not wrapped or checked; page-boundary wrap is the flash's behaviour.
- A spi_done arriving outside XWAIT is ignored.

## Timing
- Reset values: cmd_ready=0 during reset and 1 the cycle after; busy=0, done=0, error=0, status=0x00, spi_cs=0, spi_start=0, spi_tx=0x00, wr_ready=0.
- Reset mid-command: all state returns to IDLE at the next edge and spi_cs drops immediately; the in-flight byte is abandoned.
- Command accept to first spi_start: 2 cycles (CS_SETUP, XFER).
- spi_done to next spi_start within one transaction: 1 cycle for command/address bytes; for data bytes, 1 cycle after wr accept, and accept is possible in the cycle after spi_done.
- cmd_valid asserted while busy has no effect.
- done and cmd_ready never assert in the same cycle; cmd_ready rises the cycle after done.

## Test plan
- Page program, cmd_len=3, addr 0x012345, data AA BB CC DD; the SPI model returns WIP=1 twice, then 0x00:
  - bytes 06 | 02 01 23 45 AA BB CC DD | 05 00 ×3;
  - CS high ≥2 cycles between transactions; done pulses once; status=0x00; error=0.
- Sector erase at 0xABCDEF, WIP cleared on the first poll -> bytes 06 | 20 AB CD EF | 05 00; exactly one done.
- Read status with the model returning 0x5C -> bytes 05 00 only, no 06; status=0x5C; done 3 cycles after the last spi_done.
- Data stall: wr_valid low for 20 cycles after byte 1 -> spi_cs stays 1, no spi_start during the stall, sequence completes correctly.
- Timeout with MAX_POLLS=4 and the model always returning 0x01 -> exactly 4 polls, error=1, done pulse; the next accepted command clears error.
- Reset asserted during the address bytes -> spi_cs=0 and busy=0 the next cycle; a following read-status command works normally.
